// File: rtl/idecode_if.sv
// Decode-stage bus: IF/ID inputs, writeback port, flush control and the ID/EX register outputs.
interface idecode_if;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        FlushE;

  logic        RegWriteE;
  logic        MemWriteE;
  logic        JumpE;
  logic        BranchE;
  logic        ALUSrcE;
  logic        IllegalE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE,
           ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE
  );

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE,
           ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE
  );
endinterface

// File: rtl/idecode.sv
// RV32I-subset decode stage: 32x32 register file with write-through reads, control decode,
// immediate generation and the ID/EX pipeline register.
module idecode (
  input  logic      clk,
  input  logic      reset,
  idecode_if.slave  bus
);

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [31:0] rf_q [32];

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;

  assign opcode = bus.InstrD[6:0];
  assign funct3 = bus.InstrD[14:12];
  assign funct7 = bus.InstrD[31:25];
  assign rs1    = bus.InstrD[19:15];
  assign rs2    = bus.InstrD[24:20];
  assign rd     = bus.InstrD[11:7];

  // Register file; x0 is never written so it stays zero without a read-side special case on storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (bus.RegWriteW && (bus.RdW != 5'd0)) begin
      rf_q[bus.RdW] <= bus.ResultW;
    end
  end

  logic [31:0] rd1_d, rd2_d;

  always_comb begin
    rd1_d = rf_q[rs1];
    if (rs1 == 5'd0)                            rd1_d = '0;
    else if (bus.RegWriteW && (bus.RdW == rs1)) rd1_d = bus.ResultW;
    rd2_d = rf_q[rs2];
    if (rs2 == 5'd0)                            rd2_d = '0;
    else if (bus.RegWriteW && (bus.RdW == rs2)) rd2_d = bus.ResultW;
  end

  logic       reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d, illegal_d;
  logic [1:0] result_src_d;
  logic [2:0] alu_ctrl_d;
  imm_src_e   imm_src;

  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    jump_d       = 1'b0;
    branch_d     = 1'b0;
    alu_src_d    = 1'b0;
    illegal_d    = 1'b0;
    result_src_d = 2'b00;
    alu_ctrl_d   = 3'b000;
    imm_src      = IMM_I;
    unique case (opcode)
      OP_LW: begin
        reg_write_d  = 1'b1;
        alu_src_d    = 1'b1;
        result_src_d = 2'b01;
      end
      OP_SW: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_src     = IMM_S;
      end
      OP_R: begin
        reg_write_d = 1'b1;
        // Only sub uses funct7 = 0100000; every other funct7 pattern is rejected.
        if (funct7 == 7'b0100000 && funct3 == 3'b000) alu_ctrl_d = 3'b001;
        else if (funct7 != 7'b0000000)               illegal_d  = 1'b1;
        else begin
          unique case (funct3)
            3'b000:  alu_ctrl_d = 3'b000;
            3'b111:  alu_ctrl_d = 3'b010;
            3'b110:  alu_ctrl_d = 3'b011;
            3'b010:  alu_ctrl_d = 3'b101;
            default: illegal_d  = 1'b1;
          endcase
        end
      end
      OP_IALU: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        unique case (funct3)
          3'b000:  alu_ctrl_d = 3'b000;
          3'b111:  alu_ctrl_d = 3'b010;
          3'b110:  alu_ctrl_d = 3'b011;
          3'b010:  alu_ctrl_d = 3'b101;
          default: illegal_d  = 1'b1;
        endcase
      end
      OP_BEQ: begin
        imm_src = IMM_B;
        if (funct3 == 3'b000) begin
          branch_d   = 1'b1;
          alu_ctrl_d = 3'b001;
        end else begin
          illegal_d = 1'b1;
        end
      end
      OP_JAL: begin
        reg_write_d  = 1'b1;
        jump_d       = 1'b1;
        result_src_d = 2'b10;
        imm_src      = IMM_J;
      end
      default: illegal_d = 1'b1;
    endcase
    if (illegal_d) begin
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      jump_d       = 1'b0;
      branch_d     = 1'b0;
      alu_src_d    = 1'b0;
      result_src_d = 2'b00;
      alu_ctrl_d   = 3'b000;
    end
  end

  logic signed [31:0] imm_d;

  always_comb begin
    unique case (imm_src)
      IMM_S:   imm_d = {{20{bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
      IMM_B:   imm_d = {{20{bus.InstrD[31]}}, bus.InstrD[7], bus.InstrD[30:25],
                        bus.InstrD[11:8], 1'b0};
      IMM_J:   imm_d = {{12{bus.InstrD[31]}}, bus.InstrD[19:12], bus.InstrD[20],
                        bus.InstrD[30:21], 1'b0};
      default: imm_d = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
    endcase
  end

  logic        reg_write_q, mem_write_q, jump_q, branch_q, alu_src_q, illegal_q;
  logic [1:0]  result_src_q;
  logic [2:0]  alu_ctrl_q;
  logic [31:0] rd1_q, rd2_q, imm_q, pc_q, pc_plus4_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;

  // ID/EX register: flush zeroes only the state-changing controls; everything else loads as usual.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      jump_q       <= 1'b0;
      branch_q     <= 1'b0;
      alu_src_q    <= 1'b0;
      illegal_q    <= 1'b0;
      result_src_q <= 2'b00;
      alu_ctrl_q   <= 3'b000;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      pc_plus4_q   <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
    end else begin
      reg_write_q  <= reg_write_d & ~bus.FlushE;
      mem_write_q  <= mem_write_d & ~bus.FlushE;
      jump_q       <= jump_d      & ~bus.FlushE;
      branch_q     <= branch_d    & ~bus.FlushE;
      illegal_q    <= illegal_d   & ~bus.FlushE;
      alu_src_q    <= alu_src_d;
      result_src_q <= result_src_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      imm_q        <= imm_d;
      pc_q         <= bus.PCD;
      pc_plus4_q   <= bus.PCPlus4D;
      rs1_q        <= rs1;
      rs2_q        <= rs2;
      rd_q         <= rd;
    end
  end

  assign bus.RegWriteE   = reg_write_q;
  assign bus.MemWriteE   = mem_write_q;
  assign bus.JumpE       = jump_q;
  assign bus.BranchE     = branch_q;
  assign bus.ALUSrcE     = alu_src_q;
  assign bus.IllegalE    = illegal_q;
  assign bus.ResultSrcE  = result_src_q;
  assign bus.ALUControlE = alu_ctrl_q;
  assign bus.RD1E        = rd1_q;
  assign bus.RD2E        = rd2_q;
  assign bus.ImmExtE     = imm_q;
  assign bus.PCE         = pc_q;
  assign bus.PCPlus4E    = pc_plus4_q;
  assign bus.Rs1E        = rs1_q;
  assign bus.Rs2E        = rs2_q;
  assign bus.RdE         = rd_q;

endmodule

// File: doc/idecode.md
IDECODE -- requirements
Module: idecode

Interface
REQ-001 Parameters: none; data path fixed at 32 bits, register file fixed at 32 x 32.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 InstrD  in  32  decode-stage instruction from IF/ID register.
REQ-005 PCD, PCPlus4D  in  32 each  decode-stage PC and PC+4.
REQ-006 RegWriteW  in  1  writeback enable.
REQ-007 RdW  in  5  writeback destination.
REQ-008 ResultW  in  32  writeback data.
REQ-009 FlushE  in  1  insert bubble into ID/EX on next edge.
REQ-010 RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE  out  1 each  registered controls.
REQ-011 ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4.
REQ-012 ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-013 RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each  registered operands and PCs.
REQ-014 Rs1E, Rs2E, RdE  out  5 each  registered register indices (InstrD[19:15], [24:20], [11:7]).

Function
REQ-015 Register file: 32 x 32; x0 reads 0 always; write to RdW=0 ignored.
REQ-016 Write on rising clk when RegWriteW=1 and RdW!=0.
REQ-017 Read ports combinational; when RegWriteW=1, RdW!=0 and RdW equals the read index, port returns ResultW in the same cycle (write-through).
REQ-018 Decode: lw 0000011 -> RegWrite=1, ImmSrc I, ALUSrc=1, ResultSrc=01, ALU add.
REQ-019 sw 0100011 -> MemWrite=1, ImmSrc S, ALUSrc=1, ALU add.
REQ-020 R-type 0110011 -> RegWrite=1, ALUSrc=0; funct3/funct7[5]: 000/0 add, 000/1 sub, 111 and, 110 or, 010 slt.
REQ-021 I-ALU 0010011 -> RegWrite=1, ALUSrc=1; funct3 000 addi (funct7 ignored), 111 andi, 110 ori, 010 slti.
REQ-022 beq 1100011 funct3 000 -> Branch=1, ImmSrc B, ALUSrc=0, ALU sub.
REQ-023 jal 1101111 -> RegWrite=1, Jump=1, ImmSrc J, ResultSrc=10.
REQ-024 Any other opcode or unsupported funct3/funct7 -> all control bits 0, IllegalE=1 on next edge.
REQ-025 Immediates sign-extended from InstrD[31]: I {[31:20]}; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; J {[31],[19:12],[20],[30:21],0}.
REQ-026 ID/EX register: every E output loads from decode-stage values on each rising edge; latency 1 cycle.
REQ-027 FlushE=1 at an edge: RegWriteE, MemWriteE, JumpE, BranchE, IllegalE load 0; data/index fields load normally (don't-care).
REQ-028 Register-file write and ID/EX capture in the same cycle are independent; write-through guarantees the captured RD1E/RD2E reflect that write.

Reset
REQ-029 reset=0: all E outputs 0 and all 32 registers 0, asynchronously, without waiting for clk.
REQ-030 Reset asserted mid-operation discards any in-flight decode; the first edge after release captures the current InstrD normally.
REQ-031 Writes requested while reset=0 are ignored.

Verification
REQ-032 Reset: preload x5, pulse reset low between edges -> all outputs 0 before next edge; x5 reads 0.
REQ-033 Write x3=0x0000_00AA; next cycle InstrD=add x4,x3,x0 (0x00018233) -> RD1E=0xAA, RegWriteE=1, ALUControlE=000, RdE=4.
REQ-034 Same-cycle write x7=0x1234 with InstrD=addi x1,x7,-1 (0xFFF38093) -> RD1E=0x1234, ImmExtE=0xFFFF_FFFF, ALUSrcE=1.
REQ-035 Write RdW=0 ResultW=0xDEAD, then read x0 -> RD1E=0.
REQ-036 InstrD=beq x1,x2,-8 (0xFE208CE3) with FlushE=1 -> BranchE=0, RegWriteE=0; same with FlushE=0 -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFF_FFF8.
REQ-037 InstrD=0xFFFF_FFFF -> IllegalE=1, all other control outputs 0; jal x1,+16 (0x010000EF) -> JumpE=1, ResultSrcE=10, ImmExtE=0x10.
